// File: rtl/fp_align_unit_pkg.sv
// Shared constants, state encoding and helpers for the FP add/sub front end.
package fp_pkg;

  localparam int EXP_W    = 8;
  localparam int FRAC_W   = 23;
  localparam int MANT_W   = 24;
  localparam int EXP_BIAS = 127;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Bits to shift this cycle: the per-cycle step, or fewer on the last cycle.
  function automatic logic [4:0] shift_amt(input logic [4:0] remaining, input logic [4:0] step);
    return (remaining < step) ? remaining : step;
  endfunction

endpackage

// File: rtl/fp_align_unit_if.sv
// Operand/result handshake bundle between the align unit and its neighbours.
interface fp_align_unit_if;
  import fp_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [31:0]       a;
  logic [31:0]       b;
  logic              out_valid;
  logic              out_ready;
  logic              s1;
  logic              s2;
  logic [MANT_W-1:0] m1;
  logic [MANT_W-1:0] m2;
  logic [EXP_W-1:0]  e1;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, s1, s2, m1, m2, e1
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, s1, s2, m1, m2, e1
  );

endinterface

// File: rtl/fp_align_unit_unpack.sv
// Combinational binary32 unpack: sign, raw exponent, effective exponent, 24-bit mantissa.
// With FP_ALIGN_FTZ_EN defined, exp==0 inputs flush to signed zero (mant 0, effexp 0).
module fp_unpack
  import fp_pkg::*;
(
  input  logic [31:0]       word,
  output logic              sign,
  output logic [EXP_W-1:0]  exp_raw,
  output logic [EXP_W-1:0]  eff_exp,
  output logic [MANT_W-1:0] mant
);

  logic is_zero_exp;

  assign sign        = word[31];
  assign exp_raw     = word[30:23];
  assign is_zero_exp = (exp_raw == '0);

`ifdef FP_ALIGN_FTZ_EN
  assign mant    = is_zero_exp ? '0 : {1'b1, word[FRAC_W-1:0]};
  assign eff_exp = exp_raw;
`else
  // Subnormals share the exponent of the smallest normal, so they align with it.
  assign mant    = {!is_zero_exp, word[FRAC_W-1:0]};
  assign eff_exp = is_zero_exp ? 8'd1 : exp_raw;
`endif

endmodule

// File: rtl/fp_align_unit.sv
// Operand ordering and multi-cycle exponent alignment for FP add/sub.
// Optional flush-to-zero of exp==0 inputs: define FP_ALIGN_FTZ_EN.
//
//   state    | meaning
//   ---------+-----------------------------------------------------
//   ST_IDLE  | waiting for an operand pair, in_ready high
//   ST_SHIFT | shifting m2 right by up to SHIFT_STEP bits per cycle
//   ST_DONE  | result presented, held until out_ready
module fp_align_unit
  import fp_pkg::*;
#(
  parameter int SHIFT_STEP = 4
) (
  input  logic           clk,
  input  logic           rst,
  fp_align_unit_if.slave bus
);

  localparam logic [4:0] STEP = 5'(SHIFT_STEP);

  state_e            state_q, state_d;
  logic [4:0]        rem_q, rem_d;
  logic              s1_q, s1_d, s2_q, s2_d;
  logic [MANT_W-1:0] m1_q, m1_d, m2_q, m2_d;
  logic [EXP_W-1:0]  e1_q, e1_d;

  logic              sa, sb;
  logic [EXP_W-1:0]  ra, rb, ea, eb;
  logic [MANT_W-1:0] ma, mb;
  logic              a_ge_b;
  logic [EXP_W-1:0]  diff;
  logic [4:0]        amt;

  fp_unpack u_unpack_a (.word(bus.a), .sign(sa), .exp_raw(ra), .eff_exp(ea), .mant(ma));
  fp_unpack u_unpack_b (.word(bus.b), .sign(sb), .exp_raw(rb), .eff_exp(eb), .mant(mb));

  // Magnitude order on {exp, frac}; ties go to A. Flushed inputs compare with frac 0.
  assign a_ge_b = {ra, ma[FRAC_W-1:0]} >= {rb, mb[FRAC_W-1:0]};
  assign diff   = a_ge_b ? (ea - eb) : (eb - ea);
  assign amt    = shift_amt(rem_q, STEP);

  assign bus.in_ready  = (state_q == ST_IDLE) && !rst;
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.s1        = s1_q;
  assign bus.s2        = s2_q;
  assign bus.m1        = m1_q;
  assign bus.m2        = m2_q;
  assign bus.e1        = e1_q;

  // Next-state: load ordered operands on accept, shift m2 down, release on out_ready.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    m1_d    = m1_q;
    m2_d    = m2_q;
    e1_d    = e1_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          s1_d = a_ge_b ? sa : sb;
          s2_d = a_ge_b ? sb : sa;
          m1_d = a_ge_b ? ma : mb;
          m2_d = a_ge_b ? mb : ma;
          e1_d = a_ge_b ? ra : rb;
          if (diff == '0) begin
            state_d = ST_DONE;
          end else if (diff >= 8'd24) begin
            m2_d    = '0;
            state_d = ST_DONE;
          end else begin
            rem_d   = diff[4:0];
            state_d = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        m2_d  = m2_q >> amt;
        rem_d = rem_q - amt;
        if (rem_d == '0) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and result registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      m1_q    <= '0;
      m2_q    <= '0;
      e1_q    <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      m1_q    <= m1_d;
      m2_q    <= m2_d;
      e1_q    <= e1_d;
    end
  end

endmodule
